mult_issue: RTL and testbench

Request/response front-end that sits directly upstream of the iterative Booth multiplier and feeds its operand and start inputs. It accepts one multiply request at a time over a valid/ready handshake and holds both operands stable for the whole operation. It issues a single-cycle start pulse, waits for the multiplier's ready flag (with a watchdog), and returns the captured result, overflow and tag over a second valid/ready handshake.

---
 rtl/mult_issue.sv | 140 ++++++++++++++
 tb/tb_mult_issue.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_issue.sv
// Request/response front-end for the iterative Booth multiplier: holds operands,
// issues a one-cycle start pulse, waits for ready under a watchdog, returns the result.
module mult_issue #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_operandA,
    input  logic [31:0]      req_operandB,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_exception,
    output logic             rsp_timeout,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    output logic [31:0]      mult_operandA,
    output logic [31:0]      mult_operandB,
    output logic             mult_ctrl_MULT,
    input  logic [31:0]      mult_result,
    input  logic             mult_exception,
    input  logic             mult_resultRDY
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_accept;
    logic                w_capture;
    logic                w_expire;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_result;
    logic                r_exc;
    logic                r_to;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, watchdog count and capture strobes; RDY is only honoured in WAIT
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (mult_resultRDY) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_expire    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand/tag holding registers, watchdog counter and response registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_tag    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_accept) begin
                r_opa <= req_operandA;
                r_opb <= req_operandB;
                r_tag <= req_tag;
            end
            if (w_capture) begin
                r_result <= mult_result;
                r_exc    <= mult_exception;
                r_to     <= 1'b0;
            end else if (w_expire) begin
                r_result <= '0;
                r_exc    <= 1'b1;
                r_to     <= 1'b1;
            end
        end
    end

    // req_ready is gated by reset_n so it reads 0 while reset is held
    assign req_ready      = (r_state == S_IDLE) && reset_n;
    assign rsp_valid      = (r_state == S_DONE);
    assign busy           = (r_state == S_START) || (r_state == S_WAIT);
    assign mult_ctrl_MULT = (r_state == S_START);
    assign mult_operandA  = r_opa;
    assign mult_operandB  = r_opb;
    assign rsp_result     = r_result;
    assign rsp_exception  = r_exc;
    assign rsp_timeout    = r_to;
    assign rsp_tag        = r_tag;

endmodule

// File: tb/tb_mult_issue.sv
// Scoreboard bench for mult_issue: a behavioural multiplier model answers start pulses,
// the driver pushes expected responses and a negedge monitor pops and compares them.
module tb_mult_issue;

    localparam int unsigned TIMEOUT = 40;
    localparam int unsigned TAG_W   = 4;

    logic             clock = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [31:0]      req_operandA = '0;
    logic [31:0]      req_operandB = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [31:0]      rsp_result;
    logic             rsp_exception;
    logic             rsp_timeout;
    logic [TAG_W-1:0] rsp_tag;
    logic             busy;
    logic [31:0]      mult_operandA;
    logic [31:0]      mult_operandB;
    logic             mult_ctrl_MULT;
    logic [31:0]      mult_result;
    logic             mult_exception;
    logic             mult_resultRDY;

    always #5 clock = ~clock;

    mult_issue #(.TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_operandA   (req_operandA),
        .req_operandB   (req_operandB),
        .req_tag        (req_tag),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_exception  (rsp_exception),
        .rsp_timeout    (rsp_timeout),
        .rsp_tag        (rsp_tag),
        .busy           (busy),
        .mult_operandA  (mult_operandA),
        .mult_operandB  (mult_operandB),
        .mult_ctrl_MULT (mult_ctrl_MULT),
        .mult_result    (mult_result),
        .mult_exception (mult_exception),
        .mult_resultRDY (mult_resultRDY)
    );

    typedef struct {
        logic [31:0]      result;
        logic             exc;
        logic             to;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic longint prod(input logic [31:0] a, input logic [31:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    function automatic logic prod_ovf(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] lo;
        p  = 64'(prod(a, b));
        lo = p[31:0];
        return p != 64'(longint'($signed(lo)));
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Multiplier model: samples operands on start, RDY from m_delay cycles after START,
    // and keeps RDY/result high afterwards like the real unit (stale RDY).
    logic        m_run = 1'b0;
    int          m_since = 0;
    int          m_delay = 0;
    int          cur_delay = 0;
    logic [31:0] m_res = '0;
    logic        m_exc = 1'b0;

    always @(posedge clock) begin
        if (req_valid && req_ready) m_delay <= cur_delay;
        if (mult_ctrl_MULT) begin
            m_run   <= 1'b1;
            m_since <= 1;
            m_res   <= 32'(prod(mult_operandA, mult_operandB));
            m_exc   <= prod_ovf(mult_operandA, mult_operandB);
        end else if (m_run && m_since < 100000) begin
            m_since <= m_since + 1;
        end
    end

    assign mult_resultRDY = m_run && (m_delay > 0) && (m_since >= m_delay);
    assign mult_result    = m_res;
    assign mult_exception = m_exc;

    // Monitor: compares each response against the scoreboard head
    logic        prev_valid = 1'b0;
    logic        have_cur = 1'b0;
    exp_t        cur;
    int          ctrl_cnt = 0;
    logic        opnd_bad = 1'b0;
    logic [31:0] exp_opa = '0;
    logic [31:0] exp_opb = '0;

    always @(negedge clock) begin
        if (!reset_n) begin
            sb_q.delete();
            ctrl_cnt   = 0;
            opnd_bad   = 1'b0;
            prev_valid = 1'b0;
            have_cur   = 1'b0;
        end else begin
            if (mult_ctrl_MULT) ctrl_cnt++;
            if ((busy || rsp_valid) && (mult_operandA != exp_opa || mult_operandB != exp_opb))
                opnd_bad = 1'b1;
            if (rsp_valid && !prev_valid) begin
                if (sb_q.size() == 0) begin
                    have_cur = 1'b0;
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: actual result=%0h tag=%0h required no response (t=%0t)",
                             rsp_result, rsp_tag, $time);
                end else begin
                    cur      = sb_q.pop_front();
                    have_cur = 1'b1;
                    check("rsp_result", 128'(rsp_result), 128'(cur.result));
                    check("rsp_exception", 128'(rsp_exception), 128'(cur.exc));
                    check("rsp_timeout", 128'(rsp_timeout), 128'(cur.to));
                    check("rsp_tag", 128'(rsp_tag), 128'(cur.tag));
                    check("rsp_cycle", 128'(cyc), 128'(cur.cyc));
                    check("ctrl_pulses", 128'(ctrl_cnt), 128'(1));
                    check("operand_hold", 128'(opnd_bad), 128'(0));
                end
                ctrl_cnt = 0;
                opnd_bad = 1'b0;
            end else if (rsp_valid && rsp_ready && have_cur) begin
                check("rsp_hold", 128'({rsp_result, rsp_exception, rsp_timeout, rsp_tag}),
                      128'({cur.result, cur.exc, cur.to, cur.tag}));
            end
            prev_valid = rsp_valid;
        end
    end

    // Issue one request; called just after a rising edge, returns just after the accept edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                         input int d, output int n_acc);
        exp_t e;
        int   guard;
        logic to;
        cur_delay    = d;
        req_valid    = 1'b1;
        req_operandA = a;
        req_operandB = b;
        req_tag      = tag;
        guard        = 0;
        @(negedge clock);
        while (!req_ready && guard < 300) begin
            @(negedge clock);
            guard++;
        end
        if (!req_ready) begin
            fail_now("accept_timeout");
            req_valid = 1'b0;
            n_acc     = -1;
            return;
        end
        n_acc    = cyc;
        to       = (d == 0) || (d > int'(TIMEOUT));
        e.tag    = tag;
        e.to     = to;
        e.exc    = to ? 1'b1 : prod_ovf(a, b);
        e.result = to ? 32'd0 : 32'(prod(a, b));
        e.cyc    = n_acc + 2 + (to ? int'(TIMEOUT) : d);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        exp_opa   = a;
        exp_opb   = b;
    endtask

    task automatic drain(input int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if (sb_q.size() == 0 && !busy && !rsp_valid) break;
            @(posedge clock);
            #1;
        end
        if (i >= limit) fail_now("drain_timeout");
    endtask

    task automatic check_reset_vals(input string name);
        check(name, 128'({req_ready, rsp_valid, busy, mult_ctrl_MULT, rsp_exception, rsp_timeout,
                          rsp_tag, rsp_result, mult_operandA, mult_operandB}), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int r;
        int cnt;
        logic bp_bad;
        logic [31:0] a;
        logic [31:0] b;

        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("reset_vals");
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_ready", 128'(req_ready), 128'(1));
        @(posedge clock);
        #1;

        // Basic multiply; start pulse must be exactly cycle 1
        issue(32'd3, 32'd5, 4'd2, 17, n);
        check("start_pulse_c1", 128'({mult_ctrl_MULT, busy}), 128'(2'b11));
        @(posedge clock);
        #1;
        check("start_pulse_c2", 128'({mult_ctrl_MULT, busy}), 128'(2'b01));
        drain(100);

        // Stale RDY from the previous op is still high through IDLE and START
        issue(32'h1234_5678, 32'd9, 4'd5, 11, n);
        drain(100);

        // Overflow, negative and minimum-latency cases back to back
        issue(32'h4000_0000, 32'd4, 4'd3, 8, n);
        issue(-32'sd7, 32'd6, 4'd4, 3, n);
        issue(32'd100, -32'sd200, 4'd6, 1, n);
        drain(200);

        // Watchdog: RDY never, then RDY on the last WAIT cycle
        issue(32'd7, 32'd7, 4'd7, 0, n);
        drain(100);
        issue(32'd9, 32'd9, 4'd8, int'(TIMEOUT), n);
        drain(100);

        // Backpressure with a pending request held during DONE
        rsp_ready = 1'b0;
        issue(32'd11, 32'd13, 4'd9, 5, n);
        cnt = 0;
        while (!rsp_valid && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        if (!rsp_valid) fail_now("bp_rsp_wait");
        @(posedge clock);
        #1;
        req_valid    = 1'b1;
        req_operandA = 32'd21;
        req_operandB = -32'sd3;
        req_tag      = 4'd10;
        bp_bad       = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (req_ready || busy) bp_bad = 1'b1;
        end
        check("bp_no_accept", 128'(bp_bad), 128'(0));
        check("bp_valid_held", 128'(rsp_valid), 128'(1));
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        r = cyc;
        issue(32'd21, -32'sd3, 4'd10, 4, n);
        check("bp_accept_edge", 128'(n), 128'(r + 1));
        drain(100);

        // Async reset pulse 5 cycles into WAIT drops the operation
        issue(32'd5, 32'd6, 4'd11, 30, n);
        repeat (6) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_vals("reset_async");
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (rsp_valid || busy) cnt++;
        end
        check("no_rsp_after_reset", 128'(cnt), 128'(0));
        @(posedge clock);
        #1;
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd12, 6, n);
        drain(100);

        // Randomized operations including watchdog expiries
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000;
            b = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 2000)) - 32'd1000;
            issue(a, b, TAG_W'($urandom), int'($urandom_range(0, 45)), n);
        end
        drain(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
